// File: rtl/sbox_sched.sv
// Time-shared S-box scheduler: arbitrates round and key jobs onto a bank of
// pipelined S-box lanes and reassembles the returned bytes per requester.
module sbox_sched #(
    parameter int LANES    = 4,
    parameter int SBOX_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rnd_req,
    input  logic               rnd_inv,
    input  logic [127:0]       rnd_state,
    output logic               rnd_gnt,
    output logic               rnd_done,
    output logic [127:0]       rnd_result,
    input  logic               key_req,
    input  logic [31:0]        key_word,
    output logic               key_gnt,
    output logic               key_done,
    output logic [31:0]        key_result,
    output logic               sb_vld,
    output logic               sb_inv,
    output logic [8*LANES-1:0] sb_in,
    input  logic [8*LANES-1:0] sb_out
);
    localparam int BW        = 8 * LANES;
    localparam int RND_BEATS = 16 / LANES;
    localparam int KEY_BEATS = 4 / LANES;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("sbox_sched: LANES must be 1, 2 or 4");
        end
        if (SBOX_LAT < 1) begin : g_bad_lat
            $error("sbox_sched: SBOX_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    logic                last_rnd;
    logic                job_key;
    logic                job_inv;
    logic [3:0]          beat;
    logic [3:0]          last_beat;
    logic [3:0]          sb_idx;
    logic [127:0]        job_data;
    logic [BW-1:0]       beat_word;
    logic [BW-1:0]       first_word;
    logic                capture;
    logic                pick_key;
    logic                last_ret;
    logic [SBOX_LAT-1:0] ret_vld_p;
    logic [3:0]          ret_idx_p [SBOX_LAT];

    // Key wins a tie only when round was served last.
    always_comb begin
        capture    = (state == IDLE) && (rnd_req || key_req);
        pick_key   = key_req && (!rnd_req || last_rnd);
        first_word = pick_key ? key_word[BW-1:0] : rnd_state[BW-1:0];
        last_ret   = (state == DRAIN) && ret_vld_p[SBOX_LAT-1]
                     && (ret_idx_p[SBOX_LAT-1] == last_beat);
    end

    always_comb begin
        beat_word = '0;
        for (int k = 0; k < RND_BEATS; k++) begin
            if (beat == 4'(k)) beat_word = job_data[BW*k +: BW];
        end
    end

    // Job buffer carries data only; the control path decides when it is read.
    always_ff @(posedge clk) begin
        if (capture) job_data <= pick_key ? {96'b0, key_word} : rnd_state;
    end

    // Beat 0 is taken straight from the inputs so it issues alongside the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_rnd  <= 1'b1;
            job_key   <= 1'b0;
            job_inv   <= 1'b0;
            beat      <= '0;
            last_beat <= '0;
            sb_idx    <= '0;
            rnd_gnt   <= 1'b0;
            key_gnt   <= 1'b0;
            rnd_done  <= 1'b0;
            key_done  <= 1'b0;
            sb_vld    <= 1'b0;
            sb_inv    <= 1'b0;
            sb_in     <= '0;
        end else begin
            rnd_gnt  <= 1'b0;
            key_gnt  <= 1'b0;
            rnd_done <= 1'b0;
            key_done <= 1'b0;
            sb_vld   <= 1'b0;
            sb_inv   <= 1'b0;
            sb_in    <= '0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        job_key   <= pick_key;
                        job_inv   <= !pick_key && rnd_inv;
                        last_rnd  <= !pick_key;
                        rnd_gnt   <= !pick_key;
                        key_gnt   <= pick_key;
                        sb_vld    <= 1'b1;
                        sb_inv    <= !pick_key && rnd_inv;
                        sb_in     <= first_word;
                        sb_idx    <= '0;
                        beat      <= 4'd1;
                        last_beat <= pick_key ? 4'(KEY_BEATS - 1) : 4'(RND_BEATS - 1);
                        state     <= (pick_key && KEY_BEATS == 1) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    sb_vld <= 1'b1;
                    sb_inv <= job_inv;
                    sb_in  <= beat_word;
                    sb_idx <= beat;
                    beat   <= beat + 4'd1;
                    if (beat == last_beat) state <= DRAIN;
                end
                DRAIN: begin
                    if (last_ret) begin
                        rnd_done <= !job_key;
                        key_done <= job_key;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return pipeline: the beat index rides with sb_vld for SBOX_LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_vld_p  <= '0;
            for (int k = 0; k < SBOX_LAT; k++) ret_idx_p[k] <= '0;
            rnd_result <= '0;
            key_result <= '0;
        end else begin
            ret_vld_p[0] <= sb_vld;
            ret_idx_p[0] <= sb_idx;
            for (int k = 1; k < SBOX_LAT; k++) begin
                ret_vld_p[k] <= ret_vld_p[k-1];
                ret_idx_p[k] <= ret_idx_p[k-1];
            end
            if (ret_vld_p[SBOX_LAT-1]) begin
                if (job_key) begin
                    for (int k = 0; k < KEY_BEATS; k++) begin
                        if (ret_idx_p[SBOX_LAT-1] == 4'(k)) key_result[BW*k +: BW] <= sb_out;
                    end
                end else begin
                    for (int k = 0; k < RND_BEATS; k++) begin
                        if (ret_idx_p[SBOX_LAT-1] == 4'(k)) rnd_result[BW*k +: BW] <= sb_out;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_sched.sv
// Bench for sbox_sched: two instances (LANES=4/LAT=2 and LANES=1/LAT=3) driven by
// directed and random requesters, checked every cycle against a job-level model.
`timescale 1ns/1ps
module tb_sbox_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rnd_req [2];
    logic         rnd_inv [2];
    logic [127:0] rnd_state [2];
    logic         key_req [2];
    logic [31:0]  key_word [2];
    logic         rnd_gnt [2];
    logic         rnd_done [2];
    logic [127:0] rnd_result [2];
    logic         key_gnt [2];
    logic         key_done [2];
    logic [31:0]  key_result [2];
    logic         sb_vld [2];
    logic         sb_inv [2];
    logic [31:0]  sb_in4, sb_out4;
    logic [7:0]   sb_in1, sb_out1;

    sbox_sched #(.LANES(4), .SBOX_LAT(2)) u4 (
        .clk(clk), .rst_n(rst_n),
        .rnd_req(rnd_req[0]), .rnd_inv(rnd_inv[0]), .rnd_state(rnd_state[0]),
        .rnd_gnt(rnd_gnt[0]), .rnd_done(rnd_done[0]), .rnd_result(rnd_result[0]),
        .key_req(key_req[0]), .key_word(key_word[0]),
        .key_gnt(key_gnt[0]), .key_done(key_done[0]), .key_result(key_result[0]),
        .sb_vld(sb_vld[0]), .sb_inv(sb_inv[0]), .sb_in(sb_in4), .sb_out(sb_out4)
    );

    sbox_sched #(.LANES(1), .SBOX_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .rnd_req(rnd_req[1]), .rnd_inv(rnd_inv[1]), .rnd_state(rnd_state[1]),
        .rnd_gnt(rnd_gnt[1]), .rnd_done(rnd_done[1]), .rnd_result(rnd_result[1]),
        .key_req(key_req[1]), .key_word(key_word[1]),
        .key_gnt(key_gnt[1]), .key_done(key_done[1]), .key_result(key_result[1]),
        .sb_vld(sb_vld[1]), .sb_inv(sb_inv[1]), .sb_in(sb_in1), .sb_out(sb_out1)
    );

    // ---------------- reference S-box built from GF(2^8) arithmetic ----------------
    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox_t[a]  = s;
            isbox_t[s] = 8'(a);
        end
    endtask

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? isbox_t[b] : sbox_t[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sub_byte(w[8*i +: 8], inv);
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sub_byte(st[8*i +: 8], inv);
        return r;
    endfunction

    // ---------------- external lane models ----------------
    logic [31:0] lane4_p [2];
    logic [7:0]  lane1_p [3];
    always @(posedge clk) begin
        lane4_p[0] <= sub_word(sb_in4, sb_inv[0]);
        lane4_p[1] <= lane4_p[0];
        lane1_p[0] <= sub_byte(sb_in1, sb_inv[1]);
        lane1_p[1] <= lane1_p[0];
        lane1_p[2] <= lane1_p[1];
    end
    assign sb_out4 = lane4_p[1];
    assign sb_out1 = lane1_p[2];

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int inst, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    endtask

    // Job-level model: a captured job owns the lanes for BEATS+LAT+1 cycles.
    bit           m_busy [2];
    bit           m_key [2];
    bit           m_inv [2];
    bit           m_last_rnd [2];
    int           m_st [2];
    logic [127:0] m_data [2];
    logic [127:0] m_rres [2];
    logic [31:0]  m_kres [2];
    int           t_rg [2] = '{-1000, -1000};
    int           t_kg [2] = '{-1000, -1000};
    int           t_rd [2] = '{-1000, -1000};
    int           t_kd [2] = '{-1000, -1000};

    function automatic int lanes_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int job_len(input int i);
        return (m_key[i] ? 4 : 16) / lanes_of(i) + lat_of(i) + 1;
    endfunction

    task automatic compare(input int i);
        int           b, rel, dl, ln;
        bit           busy, inflight_r, inflight_k;
        logic [127:0] e_in;
        logic [31:0]  a_in;
        ln   = lanes_of(i);
        b    = (m_key[i] ? 4 : 16) / ln;
        dl   = job_len(i);
        rel  = cyc - m_st[i];
        busy = m_busy[i];
        e_in = '0;
        if (busy && rel >= 1 && rel <= b)
            e_in = (m_data[i] >> (8 * ln * (rel - 1))) & ((128'd1 << (8 * ln)) - 128'd1);
        a_in = (i == 0) ? sb_in4 : {24'b0, sb_in1};
        if (busy && rel == dl) begin
            if (m_key[i]) m_kres[i] = sub_word(m_data[i][31:0], 1'b0);
            else          m_rres[i] = sub_state(m_data[i], m_inv[i]);
        end
        inflight_r = busy && !m_key[i] && rel < dl;
        inflight_k = busy && m_key[i] && rel < dl;
        chk("rnd_gnt",  i, rnd_gnt[i],  busy && !m_key[i] && rel == 1);
        chk("key_gnt",  i, key_gnt[i],  busy && m_key[i] && rel == 1);
        chk("rnd_done", i, rnd_done[i], busy && !m_key[i] && rel == dl);
        chk("key_done", i, key_done[i], busy && m_key[i] && rel == dl);
        chk("sb_vld",   i, sb_vld[i],   busy && rel >= 1 && rel <= b);
        chk("sb_inv",   i, sb_inv[i],   busy && rel >= 1 && rel <= b && m_inv[i]);
        chk("sb_in",    i, a_in,        e_in);
        if (!inflight_r) chk("rnd_result", i, rnd_result[i], m_rres[i]);
        if (!inflight_k) chk("key_result", i, key_result[i], m_kres[i]);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i]     = 1'b0;
                m_last_rnd[i] = 1'b1;
                m_rres[i]     = '0;
                m_kres[i]     = '0;
            end else begin
                if (m_busy[i] && cyc - m_st[i] >= job_len(i)) m_busy[i] = 1'b0;
                if (!m_busy[i] && (rnd_req[i] || key_req[i])) begin
                    m_key[i]      = key_req[i] && (!rnd_req[i] || m_last_rnd[i]);
                    m_last_rnd[i] = !m_key[i];
                    m_inv[i]      = !m_key[i] && rnd_inv[i];
                    m_data[i]     = m_key[i] ? {96'b0, key_word[i]} : rnd_state[i];
                    m_st[i]       = cyc;
                    m_busy[i]     = 1'b1;
                end
            end
        end
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            compare(i);
            if (rnd_gnt[i])  t_rg[i] = cyc;
            if (key_gnt[i])  t_kg[i] = cyc;
            if (rnd_done[i]) t_rd[i] = cyc;
            if (key_done[i]) t_kd[i] = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: the request is sampled at the edge ending cycle s.
    task automatic start_job(input int i, input bit key, input logic [127:0] d,
                             input bit inv, output int s);
        if (key) begin
            key_word[i] = d[31:0];
            key_req[i]  = 1'b1;
        end else begin
            rnd_state[i] = d;
            rnd_inv[i]   = inv;
            rnd_req[i]   = 1'b1;
        end
        s = cyc;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if ((key && key_gnt[i]) || (!key && rnd_gnt[i])) break;
        end
        if (key) key_req[i] = 1'b0;
        else     rnd_req[i] = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int           s, kg_first;
        logic [127:0] exp_inv, st;
        build_tables();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rnd_req[i] = 0; key_req[i] = 0; rnd_inv[i] = 0;
            rnd_state[i] = '0; key_word[i] = '0;
        end
        chk("model_sbox_00", 0, sbox_t[0], 8'h63);
        chk("model_isbox_63", 0, isbox_t[8'h63], 8'h00);
        chk("model_isbox_7c", 0, isbox_t[8'h7c], 8'h01);
        chk("model_isbox_00", 0, isbox_t[8'h00], 8'h52);
        chk("model_subword", 0, sub_word(32'hcf4f3c09, 1'b0), 32'h8a84eb01);
        wait_n(3);
        chk("reset_rnd_result", 0, rnd_result[0], '0);
        chk("reset_sb_vld", 0, sb_vld[0], 1'b0);
        rst_n = 1'b1;
        wait_n(2);

        // Forward round job, all-zero state.
        start_job(0, 1'b0, '0, 1'b0, s);
        wait_n(10);
        chk("fwd_gnt_cycle", 0, t_rg[0] - s, 1);
        chk("fwd_done_cycle", 0, t_rd[0] - s, 7);
        chk("fwd_result", 0, rnd_result[0], {16{8'h63}});

        // Inverse round job.
        start_job(0, 1'b0, 128'h7c63, 1'b1, s);
        wait_n(10);
        exp_inv = {{14{8'h52}}, 8'h01, 8'h00};
        chk("inv_result", 0, rnd_result[0], exp_inv);

        // Key job leaves the round result alone.
        start_job(0, 1'b1, 128'hcf4f3c09, 1'b0, s);
        wait_n(8);
        chk("key_gnt_cycle", 0, t_kg[0] - s, 1);
        chk("key_done_cycle", 0, t_kd[0] - s, 4);
        chk("key_result", 0, key_result[0], 32'h8a84eb01);
        chk("key_keeps_rnd", 0, rnd_result[0], exp_inv);

        // Tie straight after reset: key first, then round wins the next tie.
        rst_n = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
        wait_n(1);
        rnd_state[0] = rand128(); rnd_inv[0] = 1'b0; key_word[0] = $urandom;
        rnd_req[0] = 1'b1; key_req[0] = 1'b1;
        s = cyc;
        kg_first = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (key_gnt[0] && kg_first < 0) kg_first = cyc - s;
            if (key_gnt[0]) key_req[0] = 1'b0;
            if (rnd_gnt[0]) rnd_req[0] = 1'b0;
            if (cyc - s == 2) begin key_word[0] = $urandom; key_req[0] = 1'b1; end
        end
        chk("tie_key_first", 0, kg_first, 1);
        chk("tie_rnd_gnt_cycle", 0, t_rg[0] - s, 5);
        chk("tie2_key_gnt_cycle", 0, t_kg[0] - s, 12);

        // Reset in cycle 3 of a round job.
        start_job(0, 1'b0, rand128(), 1'b0, s);
        wait_n(2);
        rst_n = 1'b0;
        wait_n(2);
        chk("midrst_sb_vld", 0, sb_vld[0], 1'b0);
        chk("midrst_sb_in", 0, sb_in4, '0);
        chk("midrst_rnd_result", 0, rnd_result[0], '0);
        chk("midrst_key_result", 0, key_result[0], '0);
        rst_n = 1'b1;
        wait_n(1);
        start_job(0, 1'b1, '0, 1'b0, kg_first);
        wait_n(8);
        chk("midrst_key_result_after", 0, key_result[0], 32'h63636363);
        chk("midrst_no_rnd_done", 0, t_rd[0] >= s, 1'b0);
        chk("midrst_rnd_clear", 0, rnd_result[0], '0);

        // Single-lane instance, longer latency.
        st = rand128();
        start_job(1, 1'b0, st, 1'b0, s);
        wait_n(24);
        chk("l1_done_cycle", 1, t_rd[1] - s, 20);
        chk("l1_result", 1, rnd_result[1], sub_state(st, 1'b0));

        // Random traffic on both instances, with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (rnd_req[i] && rnd_gnt[i]) rnd_req[i] = 1'b0;
                else if (!rnd_req[i] && $urandom_range(0, 3) == 0) begin
                    rnd_state[i] = rand128();
                    rnd_inv[i]   = 1'($urandom_range(0, 1));
                    rnd_req[i]   = 1'b1;
                end
                if (key_req[i] && key_gnt[i]) key_req[i] = 1'b0;
                else if (!key_req[i] && $urandom_range(0, 3) == 0) begin
                    key_word[i] = $urandom;
                    key_req[i]  = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            rnd_req[i] = 1'b0;
            key_req[i] = 1'b0;
        end
        wait_n(30);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
# sbox_sched

Time-shared S-box scheduler for the AES core. It arbitrates between the round datapath (16-byte SubBytes/InvSubBytes) and key expansion (4-byte SubWord), and streams each job through a fixed bank of `LANES` external pipelined S-box lanes. Each lane is built on the GF(2^4) inverter. Results are reassembled into a full-width result register, and completion is signalled per requester.

## Interface
- `LANES`, default 4: bytes processed per beat. Legal values are 1, 2 and 4.
- `SBOX_LAT`, default 2: fixed latency of the S-box lanes, in cycles from `sb_vld` to `sb_out`. Must be at least 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rnd_req` in 1: round-job request.
- `rnd_inv` in 1: 1 selects the inverse S-box.
- `rnd_state` in 128: input state. Byte i sits at bits [8i+7:8i].
- `rnd_gnt` out 1: one-cycle pulse; the round job has been captured.
- `rnd_done` out 1: one-cycle pulse; `rnd_result` is valid.
- `rnd_result` out 128: substituted state. Held until the next round job completes.
- `key_req` in 1: key-job request.
- `key_word` in 32: word to substitute. Byte i sits at bits [8i+7:8i].
- `key_gnt` out 1: one-cycle pulse; the key job has been captured.
- `key_done` out 1: one-cycle pulse; `key_result` is valid.
- `key_result` out 32: SubWord result. Held until the next key job completes.
- `sb_vld` out 1: beat presented to the lanes this cycle.
- `sb_inv` out 1: inverse select for the current beat.
- `sb_in` out 8*LANES: beat bytes. Lane j sits at bits [8j+7:8j].
- `sb_out` in 8*LANES: lane results, valid exactly `SBOX_LAT` cycles after the matching `sb_vld`.

## Operation
- The FSM has three states: IDLE, ISSUE and DRAIN.
- **IDLE**
  - `rnd_req` and `key_req` are sampled at each rising edge.
  - If exactly one request is high, that job is captured.
  - If both are high, the requester not served last wins (round-robin). The last-served flag resets to "round", so key wins the first tie after reset.
  - On capture, the input data, `rnd_inv` (key jobs force inv=0) and the job type are latched into an internal buffer. The matching `*_gnt` is high for the next cycle, and the FSM moves to ISSUE.
- **ISSUE**
  - Each cycle, beat k is emitted with `sb_vld`=1 and `sb_in` = buffer bytes [k*LANES .. k*LANES+LANES-1].
  - Beat count is BEATS = 16/LANES for round jobs and 4/LANES for key jobs.
  - After the last beat the FSM moves to DRAIN.
- **DRAIN**
  - No new beats are issued.
  - The FSM waits for the last beat to return, then raises `*_done` for one cycle and returns to IDLE.
- **Result collection**
  - A `SBOX_LAT`-deep shift register carries `sb_vld` together with the beat index.
  - When its output is set, `sb_out` is written into the result register of the active job at that index.
  - Only the active job's result register changes. The other requester's result register is never touched.
- **Request hold**
  - Requesters drop `*_req` after their `*_gnt`.
  - `*_req` is ignored outside IDLE, so no job is ever preempted.
  - A request still high in IDLE starts a new job.
- **Sideband values outside ISSUE**: `sb_in`=0 and `sb_inv`=0 whenever `sb_vld`=0.
- **Reset**
  - Reset is asynchronous and may assert at any point, including mid-job.
  - FSM returns to IDLE.
  - All gnt, done and `sb_*` outputs go to 0.
  - Both result registers clear to 0.
  - The valid shift register clears, so in-flight lane results are discarded.

## Timing
- Reference point: a request is sampled in IDLE at the edge ending cycle 0.
- `*_gnt` is high in cycle 1.
- Beats are issued in cycles 1..BEATS.
- Returns arrive in cycles 1+SBOX_LAT..BEATS+SBOX_LAT.
- `*_done` is high in cycle BEATS+SBOX_LAT+1, and the result is final in that same cycle.
- With LANES=4 and SBOX_LAT=2:
  - Round job: gnt in cycle 1, done in cycle 7.
  - Key job: gnt in cycle 1, done in cycle 4.
- The FSM is in IDLE during the done cycle, so a request sampled there gets its gnt in the next cycle. Back-to-back jobs therefore run with no idle cycle between them.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Round job, forward**: LANES=4, SBOX_LAT=2, `rnd_state` bytes all 0x00, inv=0.
  - `rnd_gnt` in cycle 1 and `sb_vld` high in cycles 1–4.
  - `rnd_done` in cycle 7 with `rnd_result` = all bytes 0x63.
- **Round job, inverse**: state byte0=0x63, byte1=0x7c, rest 0x00, inv=1.
  - Result byte0=0x00, byte1=0x01, rest 0x52.
- **Key job**: `key_word`=0xcf4f3c09.
  - `key_gnt` in cycle 1 and `sb_inv`=0 throughout.
  - `key_done` in cycle 4 with `key_result`=0x8a84eb01.
  - `rnd_result` is unchanged.
- **Simultaneous requests after reset**: `rnd_req` and `key_req` both high.
  - Key is granted first; the round job is granted in the cycle after `key_done`.
  - On the next tie, round wins.
- **Mid-job reset**: assert `rst_n`=0 in cycle 3 of a round job, release, then issue key job 0x00000000.
  - During reset, all outputs are 0.
  - No `rnd_done` ever appears.
  - `key_result`=0x63636363, with no stale round-beat writes.
- **LANES=1, SBOX_LAT=3**: round job.
  - 16 consecutive beats, `rnd_done` in cycle 20, result correct byte for byte against a reference S-box.
